load_use_hazard_unit: RTL and testbench
=======================================

# load_use_hazard_unit

Tracks the destination registers of in-flight instructions in the 5-stage LEGv8 pipeline and stalls issue from ID when a source operand cannot be forwarded in time. Operand forwarding covers every other RAW case; this unit covers the load-use case. It keeps a shadow pipeline of EX/MEM/WB destination records, one cycle per stage. It drives the stall and bubble controls for the PC, IF/ID and ID/EX registers, and supplies the EX/MEM destination fields consumed by operand forwarding.

## Interface
- No parameters; register index width is fixed at 5 and X31 (XZR) is 5'd31.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_valid  in  1  a real instruction sits in ID
- ID_Rn, ID_Rm, ID_Rt  in  5 each  ID source register fields
- ID_useRn, ID_useRm, ID_useRt  in  1 each  corresponding source is read by the ALU or branch logic. Store-data Rt is NOT flagged; store-data forwarding covers it.
- ID_Rd  in  5  ID destination
- ID_RegWrite  in  1  ID instruction writes ID_Rd
- ID_MemRead  in  1  ID instruction is a load (LDUR)
- ID_BRLink  in  1  ID instruction is BL (writes X30; ID_Rd ignored)
- flush  in  1  squash the instruction in ID (taken branch)
- stall  out  1  hold PC and IF/ID; combinational
- bubble  out  1  load a NOP into ID/EX this cycle; equals stall | flush
- EX_Rd, MEM_Rd  out  5 each  shadow destinations of the EX and MEM slots
- EX_RegWrite, MEM_RegWrite  out  1 each  slot valid and writes its Rd
- stall_count  out  16  saturating count of stall cycles since reset

## Operation
- Shadow slots EX, MEM, WB each hold {valid, rd[4:0], regwrite, memread}.
- Effective ID destination: rd = 30 and regwrite = 1 when ID_BRLink; otherwise ID_Rd and ID_RegWrite.
- Hazard match for source s: use_s & (s != 31) & EX.valid & EX.regwrite & EX.memread & (EX.rd == s).
- stall = ID_valid & ~flush & (match on Rn | Rm | Rt).
- Each rising edge:
  - MEM <= EX and WB <= MEM, unconditionally.
  - EX <= bubble (valid = 0) if bubble is asserted; otherwise EX <= {ID_valid, eff rd, eff regwrite, ID_MemRead}.
- flush has priority over stall. When flush is asserted, stall = 0 and bubble = 1.
- A write to X31 is tracked but never matches, because sources equal to 31 are excluded.
- EX_RegWrite = EX.valid & EX.regwrite; MEM_RegWrite = MEM.valid & MEM.regwrite. EX_Rd and MEM_Rd are driven raw from the slots.
- stall_count increments on every edge where stall = 1 and holds at 16'hFFFF.
- WB slot is internal only. It exists for a later writeback-bypass extension; no output depends on it.

## Timing
- Reset (async, rst_n = 0): all slots valid = 0, rd = 0, flags = 0.
  - Outputs under reset: stall = 0, EX/MEM RegWrite = 0, EX_Rd = MEM_Rd = 0, stall_count = 0.
  - bubble follows flush combinationally.
- stall and bubble are combinational in the same cycle as the ID inputs. Slot updates occur on the next edge.
- A load-use stall lasts exactly one cycle. After the bubble edge, the load occupies MEM and forwarding covers it. Two consecutive stall cycles for the same ID instruction is an error.
- Back-to-back loads: LDUR X1 followed by LDUR X2,[X1] stalls one cycle; this is the same rule.
- Reset deasserted mid-stream: the first post-reset cycle sees empty slots, so no stall.
- Simultaneous flush and hazard: stall = 0, bubble = 1, EX slot becomes a bubble.

## Test plan
- Load-use: LDUR X3 issues (cycle n). At n+1, ADD with Rn = 3 and useRn = 1 -> stall = 1 and bubble = 1 at n+1. At n+2, stall = 0, MEM_Rd = 3, MEM_RegWrite = 1. stall_count = 1.
- Non-load RAW: ADD X3 then SUB with Rm = 3 -> stall never asserts. Next cycle EX_Rd = 3 and EX_RegWrite = 1 (forwarding case).
- Exclusions:
  - LDUR X31 then use of Rn = 31 -> no stall.
  - LDUR X5 then STUR with data Rt = 5 and useRt = 0 -> no stall.
  - LDUR X5 then CBZ with Rt = 5 and useRt = 1 -> stall.
- BL then ADD using Rn = 30 -> EX_Rd = 30 and EX_RegWrite = 1, no stall.
- Flush with pending hazard: flush = 1 coincident with a load-use match -> stall = 0, bubble = 1. Next cycle EX_RegWrite = 0.
- Reset and saturation:
  - Assert rst_n = 0 mid-stall -> all outputs clear immediately.
  - Force 65 540 load-use stalls -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - load-use stall detection with EX/MEM/WB shadow destination slots
// Holds issue in ID for one cycle when a source needs a load still in EX.
module load_use_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_valid,
  input  logic [4:0]  ID_Rn,
  input  logic [4:0]  ID_Rm,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_useRn,
  input  logic        ID_useRm,
  input  logic        ID_useRt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_BRLink,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic [4:0]  EX_Rd,
  output logic [4:0]  MEM_Rd,
  output logic        EX_RegWrite,
  output logic        MEM_RegWrite,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  localparam logic [4:0]  XZR     = 5'd31;
  localparam logic [4:0]  LINK_RD = 5'd30;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q, wb_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic [4:0] id_rd_eff;
  logic       id_rw_eff;
  logic       ex_is_load;
  logic       hit_rn, hit_rm, hit_rt;
  logic       unused_wb;

  // X31 reads as zero, so it can never depend on an in-flight load.
  function automatic logic src_hit(input logic use_s, input logic [4:0] src,
                                   input logic ex_load, input logic [4:0] ex_rd);
    return use_s & (src != XZR) & ex_load & (ex_rd == src);
  endfunction

  always_comb begin
    id_rd_eff  = ID_BRLink ? LINK_RD : ID_Rd;
    id_rw_eff  = ID_BRLink | ID_RegWrite;
    ex_is_load = ex_q.valid & ex_q.regwrite & ex_q.memread;
    hit_rn     = src_hit(ID_useRn, ID_Rn, ex_is_load, ex_q.rd);
    hit_rm     = src_hit(ID_useRm, ID_Rm, ex_is_load, ex_q.rd);
    hit_rt     = src_hit(ID_useRt, ID_Rt, ex_is_load, ex_q.rd);
    stall      = ID_valid & ~flush & (hit_rn | hit_rm | hit_rt);
    bubble     = stall | flush;
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (!bubble) begin
      ex_d.valid    = ID_valid;
      ex_d.rd       = id_rd_eff;
      ex_d.regwrite = id_rw_eff;
      ex_d.memread  = ID_MemRead;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  // WB slot is kept for a future writeback bypass; nothing reads it yet.
  assign unused_wb = ^wb_q;

  assign EX_Rd        = ex_q.rd;
  assign MEM_Rd       = mem_q.rd;
  assign EX_RegWrite  = ex_q.valid & ex_q.regwrite;
  assign MEM_RegWrite = mem_q.valid & mem_q.regwrite;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb/tb_load_use_hazard_unit.sv - directed scoreboard bench for load_use_hazard_unit
module tb_load_use_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_valid;
  logic [4:0]  ID_Rn, ID_Rm, ID_Rt, ID_Rd;
  logic        ID_useRn, ID_useRm, ID_useRt;
  logic        ID_RegWrite, ID_MemRead, ID_BRLink;
  logic        flush;
  logic        stall, bubble;
  logic [4:0]  EX_Rd, MEM_Rd;
  logic        EX_RegWrite, MEM_RegWrite;
  logic [15:0] stall_count;

  load_use_hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rt(ID_Rt),
    .ID_useRn(ID_useRn), .ID_useRm(ID_useRm), .ID_useRt(ID_useRt),
    .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_BRLink(ID_BRLink), .flush(flush),
    .stall(stall), .bubble(bubble),
    .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  localparam int S_STALL = 0, S_BUBBLE = 1, S_EXRD = 2, S_EXRW = 3,
                 S_MEMRD = 4, S_MEMRW = 5, S_CNT = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'd0;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_STALL:  return {15'd0, stall};
      S_BUBBLE: return {15'd0, bubble};
      S_EXRD:   return {11'd0, EX_Rd};
      S_EXRW:   return {15'd0, EX_RegWrite};
      S_MEMRD:  return {11'd0, MEM_Rd};
      S_MEMRW:  return {15'd0, MEM_RegWrite};
      default:  return stall_count;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rn, input logic urn,
                          input logic [4:0] rm, input logic urm,
                          input logic [4:0] rt, input logic urt,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic bl);
    ID_valid = v;   ID_Rn = rn; ID_useRn = urn; ID_Rm = rm; ID_useRm = urm;
    ID_Rt = rt;     ID_useRt = urt; ID_Rd = rd; ID_RegWrite = rw;
    ID_MemRead = mr; ID_BRLink = bl;
  endtask

  task automatic nop();                                  drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ldur(input logic [4:0] rd, input logic [4:0] rn); drive_id(1, rn, 1, 0, 0, rd, 0, rd, 1, 1, 0); endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    drive_id(1, rn, 1, rm, 1, 0, 0, rd, 1, 0, 0);
  endtask
  task automatic stur(input logic [4:0] rt, input logic [4:0] rn); drive_id(1, rn, 1, 0, 0, rt, 0, 0, 0, 0, 0); endtask
  task automatic cbz(input logic [4:0] rt);              drive_id(1, 0, 0, 0, 0, rt, 1, 0, 0, 0, 0); endtask
  task automatic bl();                                   drive_id(1, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0, 1); endtask
  task automatic tick();                                 @(negedge clk); endtask

  initial begin
    #10000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    #2;
    push("rst_stall", S_STALL, 0);   push("rst_bubble", S_BUBBLE, 0);
    push("rst_exrd", S_EXRD, 0);     push("rst_exrw", S_EXRW, 0);
    push("rst_memrd", S_MEMRD, 0);   push("rst_memrw", S_MEMRW, 0);
    push("rst_cnt", S_CNT, 0);
    drain();
    flush = 1'b1; #1;
    push("rst_flush_bubble", S_BUBBLE, 1); push("rst_flush_stall", S_STALL, 0);
    drain();
    flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // load-use on Rn
    ldur(3, 2); #1;
    push("lu_ld_stall", S_STALL, 0); drain();
    tick(); alu(4, 3, 5); #1;
    push("lu_stall", S_STALL, 1); push("lu_bubble", S_BUBBLE, 1);
    push("lu_exrd", S_EXRD, 3);   push("lu_exrw", S_EXRW, 1);
    drain(); exp_cnt = 1;
    tick(); #1;
    push("lu_after_stall", S_STALL, 0); push("lu_after_bubble", S_BUBBLE, 0);
    push("lu_memrd", S_MEMRD, 3);       push("lu_memrw", S_MEMRW, 1);
    push("lu_exrw_bubble", S_EXRW, 0);  push("lu_cnt", S_CNT, exp_cnt);
    drain();
    tick(); nop(); #1;
    push("lu_add_exrd", S_EXRD, 4); push("lu_add_exrw", S_EXRW, 1);
    push("lu_bub_memrw", S_MEMRW, 0);
    drain();

    // non-load RAW is left to forwarding
    tick(); alu(3, 1, 2);
    tick(); alu(6, 7, 3); #1;
    push("raw_stall", S_STALL, 0); push("raw_exrd", S_EXRD, 3); push("raw_exrw", S_EXRW, 1);
    drain();

    // X31 destination never matches
    tick(); ldur(31, 2);
    tick(); alu(6, 31, 0); #1;
    push("xzr_stall", S_STALL, 0); push("xzr_exrd", S_EXRD, 31);
    drain();

    // store data Rt not flagged
    tick(); ldur(5, 2);
    tick(); stur(5, 6); #1;
    push("stur_stall", S_STALL, 0); drain();

    // CBZ reads Rt
    tick(); ldur(5, 2);
    tick(); cbz(5); #1;
    push("cbz_stall", S_STALL, 1); drain(); exp_cnt++;
    tick(); #1;
    push("cbz_once", S_STALL, 0); push("cbz_cnt", S_CNT, exp_cnt); drain();

    // Rm match
    tick(); ldur(7, 1);
    tick(); alu(8, 2, 7); #1;
    push("rm_stall", S_STALL, 1); drain(); exp_cnt++;
    tick(); #1;
    push("rm_once", S_STALL, 0); drain();

    // invalid ID never stalls
    tick(); ldur(10, 1);
    tick(); drive_id(0, 10, 1, 10, 1, 10, 1, 10, 1, 0, 0); #1;
    push("inv_stall", S_STALL, 0); push("inv_bubble", S_BUBBLE, 0); drain();
    tick(); nop(); #1;
    push("inv_exrw", S_EXRW, 0); drain();

    // BL writes X30
    tick(); bl(); #1;
    push("bl_stall", S_STALL, 0); drain();
    tick(); alu(1, 30, 2); #1;
    push("bl_use_stall", S_STALL, 0); push("bl_exrd", S_EXRD, 30); push("bl_exrw", S_EXRW, 1);
    drain();

    // flush beats a pending hazard
    tick(); ldur(8, 1);
    tick(); alu(2, 8, 0); flush = 1'b1; #1;
    push("fl_stall", S_STALL, 0); push("fl_bubble", S_BUBBLE, 1); drain();
    tick(); nop(); flush = 1'b0; #1;
    push("fl_exrw", S_EXRW, 0); push("fl_memrd", S_MEMRD, 8); push("fl_memrw", S_MEMRW, 1);
    push("fl_cnt", S_CNT, exp_cnt);
    drain();

    // back-to-back loads
    tick(); ldur(1, 2);
    tick(); ldur(2, 1); #1;
    push("b2b_stall", S_STALL, 1); drain(); exp_cnt++;
    tick(); #1;
    push("b2b_once", S_STALL, 0); push("b2b_memrd", S_MEMRD, 1); push("b2b_exrw", S_EXRW, 0);
    drain();
    tick(); nop(); #1;
    push("b2b_exrd", S_EXRD, 2); push("b2b_exrw2", S_EXRW, 1); push("b2b_cnt", S_CNT, exp_cnt);
    drain();

    // async reset mid-stall
    tick(); ldur(9, 1);
    tick(); alu(2, 9, 0); #1;
    push("mrst_pre_stall", S_STALL, 1); drain();
    rst_n = 1'b0; #1;
    push("mrst_stall", S_STALL, 0);  push("mrst_bubble", S_BUBBLE, 0);
    push("mrst_exrd", S_EXRD, 0);    push("mrst_exrw", S_EXRW, 0);
    push("mrst_memrd", S_MEMRD, 0);  push("mrst_memrw", S_MEMRW, 0);
    push("mrst_cnt", S_CNT, 0);
    drain();
    tick(); rst_n = 1'b1; #1;
    push("mrst_first_stall", S_STALL, 0); drain();
    tick(); nop();

    // saturation, starting the counter just below the top
    tick(); force dut.stall_count_q = 16'hFFF0;
    tick(); release dut.stall_count_q;
    ldur(1, 1);
    for (int i = 0; i < 40; i++) begin
      #1;
      push($sformatf("sat_stall_%0d", i), S_STALL, (i % 2 == 1) ? 16'd1 : 16'd0);
      if (i == 20) push("sat_cnt_mid", S_CNT, 16'hFFFA);
      drain();
      tick();
    end
    #1;
    push("sat_cnt_hold", S_CNT, 16'hFFFF); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
